dmi_jtag_dr_ctrl: RTL and testbench

Data-register controller that sits behind the debug JTAG TAP. It owns the DTMCS and DMI shift registers, driven by the TAP's capture/shift/update strobes. It sequences DMI read/write transactions toward the debug module over a valid/ready request/response interface and keeps the sticky DMI error status. All logic runs on TCK, so there is no clock-domain crossing inside this block.

---
 rtl/dmi_jtag_dr_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_dmi_jtag_dr_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_jtag_dr_ctrl.sv
// DTMCS / DMI data-register controller behind the debug JTAG TAP.
// Owns both DR shift chains, sequences DMI read/write requests toward the
// debug module and keeps the sticky DMI error status. Single clock (TCK).
module dmi_jtag_dr_ctrl #(
    parameter int unsigned AddrWidth  = 7,
    parameter logic [2:0]  IdleCycles = 3'd1
) (
    input  logic                 tck_i,
    input  logic                 trst_ni,
    input  logic                 capture_i,
    input  logic                 shift_i,
    input  logic                 update_i,
    input  logic                 tdi_i,
    input  logic                 dtmcs_select_i,
    output logic                 dtmcs_tdo_o,
    input  logic                 dmi_select_i,
    output logic                 dmi_tdo_o,
    output logic                 dmi_rst_no,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [AddrWidth-1:0] dmi_req_addr_o,
    output logic [1:0]           dmi_req_op_o,
    output logic [31:0]          dmi_req_data_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [31:0]          dmi_resp_data_i,
    input  logic [1:0]           dmi_resp_i
);

    localparam int unsigned DmiWidth = AddrWidth + 34;

    localparam logic [1:0] OpRead    = 2'd1;
    localparam logic [1:0] OpWrite   = 2'd2;
    localparam logic [1:0] RespFail  = 2'd2;
    localparam logic [1:0] RespBusy  = 2'd3;
    localparam logic [1:0] ErrBusy   = 2'd3;

    typedef enum logic [2:0] {
        Idle      = 3'd0,
        Read      = 3'd1,
        WaitRead  = 3'd2,
        Write     = 3'd3,
        WaitWrite = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            error_q, error_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [1:0]            op_q, op_d;
    logic                  hardreset_q;
    logic [31:0]           dtmcs_sr;
    logic [DmiWidth-1:0]   dmi_sr;

    logic                  dtmcs_capture, dtmcs_shift, dtmcs_update;
    logic                  dmi_capture, dmi_shift, dmi_update;
    logic [31:0]           dtmcs_capture_val;
    logic [1:0]            dmi_capture_op;
    logic [AddrWidth-1:0]  sr_addr;
    logic [31:0]           sr_data;
    logic [1:0]            sr_op;

    assign dtmcs_capture = dtmcs_select_i & capture_i;
    assign dtmcs_shift   = dtmcs_select_i & shift_i;
    assign dtmcs_update  = dtmcs_select_i & update_i;
    assign dmi_capture   = dmi_select_i & capture_i;
    assign dmi_shift     = dmi_select_i & shift_i;
    assign dmi_update    = dmi_select_i & update_i;

    // Busy reported in op field whenever a transaction is still in flight.
    assign dmi_capture_op    = (state_q != Idle) ? ErrBusy : error_q;
    assign dtmcs_capture_val = {14'b0, 1'b0, 1'b0, 1'b0, IdleCycles, error_q,
                                6'(AddrWidth), 4'd1};

    assign sr_addr = dmi_sr[DmiWidth-1:34];
    assign sr_data = dmi_sr[33:2];
    assign sr_op   = dmi_sr[1:0];

    assign dtmcs_tdo_o    = dtmcs_sr[0];
    assign dmi_tdo_o      = dmi_sr[0];
    assign dmi_rst_no     = ~hardreset_q;
    assign dmi_req_addr_o = addr_q;
    assign dmi_req_op_o   = op_q;
    assign dmi_req_data_o = data_q;

    // DTMCS shift chain: capture status word, shift LSB first.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            dtmcs_sr <= '0;
        end else if (dtmcs_capture) begin
            dtmcs_sr <= dtmcs_capture_val;
        end else if (dtmcs_shift) begin
            dtmcs_sr <= {tdi_i, dtmcs_sr[31:1]};
        end
    end

    // DMI shift chain: capture {addr, data, status}, shift LSB first.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            dmi_sr <= '0;
        end else if (dmi_capture) begin
            dmi_sr <= {addr_q, data_q, dmi_capture_op};
        end else if (dmi_shift) begin
            dmi_sr <= {tdi_i, dmi_sr[DmiWidth-1:1]};
        end
    end

    // Transaction state, latched payload, sticky error and hardreset pulse.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q     <= Idle;
            error_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            op_q        <= '0;
            hardreset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            error_q     <= error_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            op_q        <= op_d;
            hardreset_q <= dtmcs_update & dtmcs_sr[17];
        end
    end

    // Next-state, error and handshake decode; DTMCS reset requests are
    // evaluated last so they override everything else in the same cycle.
    always_comb begin
        state_d          = state_q;
        error_d          = error_q;
        addr_d           = addr_q;
        data_d           = data_q;
        op_d             = op_q;
        dmi_req_valid_o  = 1'b0;
        dmi_resp_ready_o = 1'b0;

        unique case (state_q)
            Read, Write: begin
                dmi_req_valid_o = 1'b1;
                if (dmi_req_ready_i) begin
                    state_d = (state_q == Read) ? WaitRead : WaitWrite;
                end
            end
            WaitRead, WaitWrite: begin
                dmi_resp_ready_o = 1'b1;
                if (dmi_resp_valid_i) begin
                    if (state_q == WaitRead) begin
                        data_d = dmi_resp_data_i;
                    end
                    if (error_q == 2'd0) begin
                        if (dmi_resp_i == RespFail) begin
                            error_d = RespFail;
                        end else if (dmi_resp_i == RespBusy) begin
                            error_d = ErrBusy;
                        end
                    end
                    state_d = Idle;
                end
            end
            default: ;
        endcase

        // Scanning DMI while busy latches a sticky busy error.
        if (dmi_capture && state_q != Idle && error_q == 2'd0) begin
            error_d = ErrBusy;
        end

        // Updates are only decoded while no error is pending.
        if (dmi_update && error_q == 2'd0) begin
            if (state_q != Idle) begin
                error_d = ErrBusy;
            end else if (sr_op == OpRead || sr_op == OpWrite) begin
                addr_d  = sr_addr;
                data_d  = sr_data;
                op_d    = sr_op;
                state_d = (sr_op == OpRead) ? Read : Write;
            end
        end

        if (dtmcs_update && (dtmcs_sr[16] || dtmcs_sr[17])) begin
            error_d = 2'd0;
        end
        if (dtmcs_update && dtmcs_sr[17]) begin
            state_d = Idle;
        end
    end

endmodule

// File: tb/tb_dmi_jtag_dr_ctrl.sv
// Scoreboard bench for dmi_jtag_dr_ctrl: expected DR scan-outs and DMI
// requests are queued by the stimulus and consumed by independent monitors.
module tb_dmi_jtag_dr_ctrl;

    logic        tck = 1'b0;
    logic        trst_n;
    logic        capture, shift, update, tdi;
    logic        dtmcs_select, dmi_select;
    logic        dtmcs_tdo, dmi_tdo, dmi_rst_n;
    logic        req_valid, req_ready;
    logic [6:0]  req_addr;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp;

    dmi_jtag_dr_ctrl #(.AddrWidth(7), .IdleCycles(3'd1)) dut (
        .tck_i            (tck),
        .trst_ni          (trst_n),
        .capture_i        (capture),
        .shift_i          (shift),
        .update_i         (update),
        .tdi_i            (tdi),
        .dtmcs_select_i   (dtmcs_select),
        .dtmcs_tdo_o      (dtmcs_tdo),
        .dmi_select_i     (dmi_select),
        .dmi_tdo_o        (dmi_tdo),
        .dmi_rst_no       (dmi_rst_n),
        .dmi_req_valid_o  (req_valid),
        .dmi_req_ready_i  (req_ready),
        .dmi_req_addr_o   (req_addr),
        .dmi_req_op_o     (req_op),
        .dmi_req_data_o   (req_data),
        .dmi_resp_valid_i (resp_valid),
        .dmi_resp_ready_o (resp_ready),
        .dmi_resp_data_i  (resp_data),
        .dmi_resp_i       (resp)
    );

    always #5 tck = ~tck;

    typedef struct {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic [63:0] val;
        string       name;
    } dr_t;

    req_t exp_req[$];
    dr_t  exp_dr[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model of the controller's architectural state.
    logic [6:0]  m_addr;
    logic [31:0] m_data;
    logic [1:0]  m_err;
    logic [1:0]  m_op;
    bit          m_busy;

    // Debug-module responder knobs.
    logic [1:0]  rsp_code;
    logic [31:0] rsp_data;
    int          rdy_dly, rsp_dly;
    bit          stall_ready, stall_resp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: DMI requests are compared against the queue every cycle they
    // are presented and popped on the handshake.
    always @(negedge tck) begin
        if (trst_n && req_valid) begin
            if (exp_req.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_req: got addr %0h op %0h data %0h expected none",
                         req_addr, req_op, req_data);
            end else begin
                chk("req_addr", 64'(req_addr), 64'(exp_req[0].addr));
                chk("req_op",   64'(req_op),   64'(exp_req[0].op));
                chk("req_data", 64'(req_data), 64'(exp_req[0].data));
                if (req_ready) void'(exp_req.pop_front());
            end
        end
    end

    // Monitor: collect TDO during shift, compare the captured word on update.
    logic [63:0] coll = '0;
    int          coll_n = 0;
    always @(negedge tck) begin
        if (shift) begin
            coll[coll_n] = dmi_select ? dmi_tdo : dtmcs_tdo;
            coll_n++;
        end
        if (update) begin
            if (exp_dr.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_scan: got %0h expected none", coll);
            end else begin
                dr_t e;
                e = exp_dr.pop_front();
                chk(e.name, coll, e.val);
            end
            coll   = '0;
            coll_n = 0;
        end
    end

    // Debug-module model: accepts requests and answers with the programmed response.
    initial begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        resp       = '0;
        forever begin
            @(posedge tck); #2;
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            if (req_valid && !stall_ready) begin
                repeat (rdy_dly) begin @(posedge tck); #2; end
                req_ready = 1'b1;
                @(posedge tck); #2;
                req_ready = 1'b0;
                repeat (rsp_dly) begin @(posedge tck); #2; end
                if (!stall_resp) begin
                    resp_valid = 1'b1;
                    resp_data  = rsp_data;
                    resp       = rsp_code;
                end
            end
        end
    end

    task automatic dr_scan(input bit is_dmi, input int len, input logic [63:0] din,
                           input logic [63:0] e, input string name);
        exp_dr.push_back('{e, name});
        dtmcs_select = !is_dmi;
        dmi_select   = is_dmi;
        capture      = 1'b1;
        @(posedge tck); #2;
        capture = 1'b0;
        shift   = 1'b1;
        for (int i = 0; i < len; i++) begin
            tdi = din[i];
            @(posedge tck); #2;
        end
        shift  = 1'b0;
        tdi    = 1'b0;
        update = 1'b1;
        @(posedge tck); #2;
        update       = 1'b0;
        dtmcs_select = 1'b0;
        dmi_select   = 1'b0;
    endtask

    task automatic dtmcs_access(input logic [31:0] din);
        logic [63:0] e;
        e = {32'b0, 14'b0, 3'b0, 3'd1, m_err, 6'd7, 4'd1};
        if (din[16] || din[17]) m_err = 2'd0;
        if (din[17]) m_busy = 1'b0;
        dr_scan(1'b0, 32, {32'b0, din}, e, "dtmcs_capture");
    endtask

    task automatic dmi_access(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
        logic [63:0] e;
        e = {23'b0, m_addr, m_data, (m_busy ? 2'd3 : m_err)};
        if (m_busy && m_err == 2'd0) m_err = 2'd3;
        if (m_err == 2'd0) begin
            if (m_busy) begin
                m_err = 2'd3;
            end else if (op == 2'd1 || op == 2'd2) begin
                exp_req.push_back('{a, op, d});
                m_addr = a;
                m_data = d;
                m_op   = op;
                m_busy = 1'b1;
            end
        end
        dr_scan(1'b1, 41, {23'b0, a, d, op}, e, "dmi_capture");
    endtask

    task automatic model_complete();
        if (m_op == 2'd1) m_data = rsp_data;
        if (m_err == 2'd0 && rsp_code == 2'd2) m_err = 2'd2;
        else if (m_err == 2'd0 && rsp_code == 2'd3) m_err = 2'd3;
        m_busy = 1'b0;
    endtask

    task automatic settle();
        repeat (14) begin @(posedge tck); #2; end
        chk("idle_after_txn", 64'({req_valid, resp_ready}), 64'd0);
        if (m_busy) model_complete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        trst_n = 1'b0;
        capture = 1'b0; shift = 1'b0; update = 1'b0; tdi = 1'b0;
        dtmcs_select = 1'b0; dmi_select = 1'b0;
        rsp_code = 2'd0; rsp_data = '0; rdy_dly = 0; rsp_dly = 0;
        stall_ready = 1'b0; stall_resp = 1'b0;
        m_addr = '0; m_data = '0; m_err = '0; m_op = '0; m_busy = 1'b0;

        #1;
        chk("rst_req_valid",  64'(req_valid),  64'd0);
        chk("rst_resp_ready", 64'(resp_ready), 64'd0);
        chk("rst_dmi_rst_n",  64'(dmi_rst_n),  64'd1);
        chk("rst_req_op",     64'(req_op),     64'd0);
        chk("rst_req_addr",   64'(req_addr),   64'd0);
        chk("rst_req_data",   64'(req_data),   64'd0);
        chk("rst_tdo",        64'({dtmcs_tdo, dmi_tdo}), 64'd0);
        repeat (3) @(posedge tck);
        #2;
        trst_n = 1'b1;
        @(posedge tck); #2;

        // DTMCS status word after reset (0x00001071 for 7 address bits)
        dtmcs_access(32'h0);

        // write with immediate handshake and response
        dmi_access(2'd2, 7'h10, 32'hDEADBEEF);
        #1;
        chk("req_valid_after_update", 64'(req_valid), 64'd1);
        #1;
        settle();
        dmi_access(2'd0, 7'h00, 32'h0);

        // read returns response data on the next capture
        rsp_data = 32'h12345678;
        dmi_access(2'd1, 7'h11, 32'h0);
        settle();
        dmi_access(2'd0, 7'h00, 32'h0);

        // busy: a scan during a stalled request reports op=3, second access dropped
        stall_ready = 1'b1;
        dmi_access(2'd2, 7'h22, 32'hA5A5A5A5);
        repeat (3) begin @(posedge tck); #2; end
        dmi_access(2'd2, 7'h33, 32'h11112222);
        dtmcs_access(32'h0);
        stall_ready = 1'b0;
        settle();
        dtmcs_access(32'h0001_0000);
        dtmcs_access(32'h0);

        // failed response is sticky until dmireset
        rsp_code = 2'd2;
        dmi_access(2'd2, 7'h05, 32'h0000_0005);
        settle();
        rsp_code = 2'd0;
        dmi_access(2'd2, 7'h06, 32'h0000_0006);
        settle();
        dtmcs_access(32'h0001_0000);
        dtmcs_access(32'h0);
        dmi_access(2'd2, 7'h07, 32'h0000_0007);
        settle();

        // hardreset while waiting for a read response
        stall_resp = 1'b1;
        dmi_access(2'd1, 7'h12, 32'hCAFEF00D);
        repeat (4) begin @(posedge tck); #2; end
        #1;
        chk("wait_resp_ready", 64'(resp_ready), 64'd1);
        #1;
        dtmcs_access(32'h0002_0000);
        @(negedge tck);
        chk("hardreset_pulse_low", 64'(dmi_rst_n),  64'd0);
        chk("hardreset_resp_ready", 64'(resp_ready), 64'd0);
        chk("hardreset_req_valid",  64'(req_valid),  64'd0);
        @(negedge tck);
        chk("hardreset_pulse_end", 64'(dmi_rst_n), 64'd1);
        stall_resp = 1'b0;
        @(posedge tck); #2;
        dmi_access(2'd0, 7'h00, 32'h0);

        // asynchronous reset in the middle of a read request
        stall_ready = 1'b1;
        dmi_access(2'd1, 7'h44, 32'h0);
        @(posedge tck); #2;
        chk("mid_read_valid", 64'(req_valid), 64'd1);
        trst_n = 1'b0;
        #1;
        chk("trst_req_valid", 64'(req_valid), 64'd0);
        chk("trst_req_addr",  64'(req_addr),  64'd0);
        chk("trst_dmi_rst_n", 64'(dmi_rst_n), 64'd1);
        #1;
        trst_n = 1'b1;
        exp_req.delete();
        m_addr = '0; m_data = '0; m_err = '0; m_op = '0; m_busy = 1'b0;
        stall_ready = 1'b0;
        @(posedge tck); #2;
        dtmcs_access(32'h0);
        dmi_access(2'd0, 7'h00, 32'h0);

        // randomized mix of DMI accesses, responses and DTMCS resets
        for (int it = 0; it < 60; it++) begin
            int unsigned r;
            rdy_dly = int'($urandom_range(0, 3));
            rsp_dly = int'($urandom_range(0, 3));
            r = $urandom_range(0, 7);
            rsp_code = (r < 6) ? 2'd0 : ((r == 6) ? 2'd2 : 2'd3);
            rsp_data = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                logic [31:0] din;
                din     = $urandom;
                din[16] = ($urandom_range(0, 1) == 1);
                din[17] = ($urandom_range(0, 7) == 0);
                dtmcs_access(din);
                @(posedge tck); #2;
            end else begin
                dmi_access(2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)), $urandom);
                settle();
            end
        end
        dmi_access(2'd0, 7'h00, 32'h0);
        dtmcs_access(32'h0);

        repeat (2) begin @(posedge tck); #2; end
        chk("req_queue_drained", 64'(exp_req.size()), 64'd0);
        chk("scan_queue_drained", 64'(exp_dr.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
